systolic_array_unit: RTL and testbench
======================================

# systolic_array_unit

Weight-stationary COLS×COLS systolic array of multiply-accumulate PEs with hard-wired ±1 weights. Inside the NPU datapath, it multiplies a ROWS×COLS signed input matrix A by the fixed weight matrix W. It records the bottom-edge partial-sum wavefront every compute cycle into an OUTPUT_ROWS×COLS result buffer. A start pulse launches one run, and `done` reports completion.

## Interface
- WIDTH, 16: signed data, accumulator and result width.
- ROWS, 10: rows of A; must equal COLS.
- COLS, 10: columns of A, and PE grid dimension.
- OUTPUT_ROWS, 38: number of compute cycles and result rows; must be ≥ ROWS+2·COLS−1.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous and active-low.
- start  in  1  single-cycle launch request.
- A  in  signed [WIDTH-1:0] [ROWS][COLS]  input matrix; sampled only on the start-accept edge.
- done  out  1  high while results are complete and stable.
- A_result  out  signed [WIDTH-1:0] [OUTPUT_ROWS][COLS]  captured bottom-edge psums, one row per compute cycle.

## Operation
- Weights W[k][j] = +1 for k < COLS/2, and −1 otherwise, for every column j. The weights are constants.
- Multiply is add/subtract only. All arithmetic is WIDTH-bit two's complement and wraps with no saturation.
- PE(k,j) update each compute cycle:
  - a_reg ← a_in
  - psum_reg ← psum_in + W[k][j]·a_in
- PE(k,j) sources:
  - a_in comes from PE(k,j−1).a_reg, or from the row-k feed when j = 0.
  - psum_in comes from PE(k−1,j).psum_reg, or 0 when k = 0.
- Row-k feed at compute cycle t is A_buf[t−k][k] when 0 ≤ t−k < ROWS, and 0 otherwise (skewed injection).
- Result property: C[r][j] = Σ_k A[r][k]·W[k][j] appears at A_result[r+j+COLS][j]. Every other A_result entry is 0.
- FSM states IDLE, RUN, DONE:
  - IDLE, start=1: A_buf ← A, all PE registers ← 0, cnt ← 0, go to RUN.
  - RUN, each edge: A_result[cnt] ← the current PE(COLS−1,*).psum_reg values (pre-update), then PEs update with feed t = cnt, then cnt++.
  - RUN, edge with cnt = OUTPUT_ROWS−1: perform the capture and update, then go to DONE.
  - DONE: done = 1 and A_result is held. start=1 behaves as in IDLE and begins a new run; done drops.
- start is ignored during RUN.
- A_result rows are not cleared at the start of a run; every row is overwritten during the run.

## Timing
- Reset (rst=0 at an edge) has priority over everything:
  - state ← IDLE, done ← 0.
  - A_result ← all zeros; PE registers, A_buf and cnt ← 0.
  - A reset during RUN aborts the run.
- done is a registered output equal to (state == DONE).
- If start is accepted at edge E0, capture edges are E1…E_OUTPUT_ROWS and done is first high after edge E_OUTPUT_ROWS (38 cycles).
- A may change freely after the start-accept edge.

## Structure
- Shared package `systolic_pkg`:
  - Default parameters WIDTH, ROWS, COLS, OUTPUT_ROWS.
  - State enum {IDLE, RUN, DONE}.
  - Weight function w(k) returning ±1.
- One sub-module, `systolic_pe`:
  - Parameter WIDTH and a 1-bit weight-sign parameter.
  - Ports clk, rst, clr, en, a_in, psum_in, a_out, psum_out.
  - Instantiated COLS×COLS by generate.
- The top holds the FSM, cnt, A_buf, the skew feed mux and the A_result capture.

## Test plan
- Reset: hold rst=0 for 2 edges → done=0 and every A_result entry is 0, with no X.
- Full run with the standard 10×10 matrix, starting with row 0 = {123,45,89,200,34,67,155,210,11,98}:
  - done rises 38 cycles after start.
  - A_result[10][0] = −50 and A_result[19][9] = −50.
  - A_result[11][0] = −31 for row 1 = {76,233,54,128,99,177,32,145,66,201}.
  - A_result[19][0] = 148 and A_result[28][9] = 148 for row 9 = {53,188,77,199,122,34,156,89,200,12}.
- Zero pattern: after the full run, A_result[t][j] = 0 whenever t−j−10 ∉ [0,9], e.g. rows 0–9, row 29 and row 37 are all zero.
- Wrap: A all 32767 → C = 5·32767 − 5·32767 = 0. Intermediate sums wrap, yet every A_result[r+j+10][j] = 0.
- Mid-run reset: assert rst=0 at cycle 15 of RUN → next cycle done=0 and A_result is all 0. A fresh start then reproduces the full-run values.
- Restart from DONE: pulse start with a new A → done falls, then rises 38 cycles later with results for the new A. A start pulse during RUN has no effect.

Source files
------------

// File: rtl/systolic_array_unit_pkg.sv
// Shared definitions for the systolic array: default sizes, FSM state type and the
// hard-wired weight pattern.
package systolic_pkg;

  localparam int unsigned DefWidth      = 16;
  localparam int unsigned DefRows       = 10;
  localparam int unsigned DefCols       = 10;
  localparam int unsigned DefOutputRows = 38;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Upper half of the PE rows adds, lower half subtracts.
  function automatic int w(int unsigned k, int unsigned cols = DefCols);
    return (k < cols / 2) ? 1 : -1;
  endfunction

endpackage

// File: rtl/systolic_array_unit_if.sv
// Launch/result bus between the NPU controller and the systolic array.
interface systolic_array_unit_if #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ROWS        = 10,
  parameter int unsigned COLS        = 10,
  parameter int unsigned OUTPUT_ROWS = 38
);
  logic                    start;
  logic signed [WIDTH-1:0] A        [ROWS][COLS];
  logic                    done;
  logic signed [WIDTH-1:0] A_result [OUTPUT_ROWS][COLS];

  modport master (output start, A, input done, A_result);
  modport slave  (input start, A, output done, A_result);
endinterface

// File: rtl/systolic_array_unit_pe.sv
// Weight-stationary PE with a constant +/-1 weight: the multiply reduces to add or subtract.
module systolic_pe #(
  parameter int unsigned WIDTH = 16,
  parameter bit          NEG   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] psum_in,
  output logic signed [WIDTH-1:0] a_out,
  output logic signed [WIDTH-1:0] psum_out
);

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] psum_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      a_q    <= '0;
      psum_q <= '0;
    end else if (en) begin
      a_q    <= a_in;
      psum_q <= NEG ? (psum_in - a_in) : (psum_in + a_in);
    end
  end

  assign a_out    = a_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_array_unit.sv
// COLS x COLS weight-stationary systolic array with skewed row feed and per-cycle capture of
// the bottom-edge partial sums into the result buffer.
module systolic_array_unit
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned ROWS        = DefRows,
  parameter int unsigned COLS        = DefCols,
  parameter int unsigned OUTPUT_ROWS = DefOutputRows
) (
  input logic                  clk,
  input logic                  rst,
  systolic_array_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(OUTPUT_ROWS);
  localparam int unsigned RW = $clog2(ROWS);

  state_e                  state_q;
  logic                    done_q;
  logic [CW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] a_buf_q    [ROWS][COLS];
  logic signed [WIDTH-1:0] a_result_q [OUTPUT_ROWS][COLS];

  logic signed [WIDTH-1:0] feed      [COLS];
  logic signed [WIDTH-1:0] a_in_w    [COLS][COLS];
  logic signed [WIDTH-1:0] psum_in_w [COLS][COLS];
  logic signed [WIDTH-1:0] a_w       [COLS][COLS];
  logic signed [WIDTH-1:0] psum_w    [COLS][COLS];

  logic accept;
  logic pe_en;

  assign accept = (state_q != StRun) && bus.start;
  assign pe_en  = (state_q == StRun);

  // Row k sees A_buf[t-k][k] while t-k is inside the matrix, zero otherwise.
  for (genvar k = 0; k < COLS; k++) begin : g_feed
    logic [CW-1:0] d;
    assign d       = cnt_q - CW'(k);
    assign feed[k] = (cnt_q >= CW'(k) && d < CW'(ROWS)) ? a_buf_q[d[RW-1:0]][k] : '0;
  end

  for (genvar k = 0; k < COLS; k++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == 0) begin : g_left
        assign a_in_w[k][j] = feed[k];
      end else begin : g_inner
        assign a_in_w[k][j] = a_w[k][j-1];
      end
      if (k == 0) begin : g_top
        assign psum_in_w[k][j] = '0;
      end else begin : g_below
        assign psum_in_w[k][j] = psum_w[k-1][j];
      end

      systolic_pe #(
        .WIDTH (WIDTH),
        .NEG   (w(k, COLS) < 0)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (pe_en),
        .a_in     (a_in_w[k][j]),
        .psum_in  (psum_in_w[k][j]),
        .a_out    (a_w[k][j]),
        .psum_out (psum_w[k][j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      a_buf_q    <= '{default: '0};
      a_result_q <= '{default: '0};
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_buf_q <= bus.A;
            cnt_q   <= '0;
            state_q <= StRun;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          // Capture happens before the PE update on the same edge.
          a_result_q[cnt_q] <= psum_w[COLS-1];
          cnt_q             <= cnt_q + 1'b1;
          if (cnt_q == CW'(OUTPUT_ROWS - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done     = done_q;
  assign bus.A_result = a_result_q;

endmodule

// File: tb/tb_systolic_array_unit.sv
// Directed self-checking bench for systolic_array_unit with hand-derived expected values.
module tb_systolic_array_unit;

  localparam int W  = 16;
  localparam int R  = 10;
  localparam int C  = 10;
  localparam int OR = 38;

  logic clk = 1'b0;
  logic rst = 1'b0;

  systolic_array_unit_if #(.WIDTH(W), .ROWS(R), .COLS(C), .OUTPUT_ROWS(OR)) bus ();

  systolic_array_unit #(
    .WIDTH       (W),
    .ROWS        (R),
    .COLS        (C),
    .OUTPUT_ROWS (OR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int std_flat [100] = '{
    123,  45,  89, 200,  34,  67, 155, 210,  11,  98,
     76, 233,  54, 128,  99, 177,  32, 145,  66, 201,
     12,  34,  56,  78,  90,  21,  43,  65,  87,   9,
    250,   1,  17,  33, 144,   8,  99,  61,  72,   5,
      3, 141,  59,  26,  53,  58,  97,  93,  23,  84,
     62,  64,  33,  83,  27,  95,   2,  88,  41,  97,
     16,  93,  99,  37,  51,   5,  82,   9,  74,  94,
     45,  92,  30,  78,  16,  40,  62,  86,  20,  89,
     98,  62,  80,  34,  82,  53,  42,  11,  70,  67,
     53, 188,  77, 199, 122,  34, 156,  89, 200,  12
  };

  // sel 0: standard matrix, 1: r*k-20 (row sums give -25*r), 2: all 32767, 3: all 1000
  function automatic logic signed [15:0] get_a(int sel, int r, int k);
    case (sel)
      0:       return 16'(std_flat[r*10+k]);
      1:       return 16'(r*k - 20);
      2:       return 16'sd32767;
      default: return 16'sd1000;
    endcase
  endfunction

  // Expected A_result[t][j]; sel < 0 means an all-zero buffer.
  function automatic logic signed [15:0] exp_entry(int sel, int t, int j);
    int r;
    logic signed [15:0] acc;
    r   = t - j - 10;
    acc = '0;
    if (sel < 0 || r < 0 || r > 9) return '0;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) acc = acc + get_a(sel, r, k);
      else       acc = acc - get_a(sel, r, k);
    end
    return acc;
  endfunction

  function automatic int count_bad(int sel);
    int bad;
    bad = 0;
    for (int t = 0; t < OR; t++)
      for (int j = 0; j < C; j++)
        if (bus.A_result[t][j] !== exp_entry(sel, t, j)) bad++;
    return bad;
  endfunction

  task automatic load(input int sel);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < C; k++)
        bus.A[r][k] = get_a(sel, r, k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch with matrix sel, scramble A after accept, optionally pulse start again mid-run.
  task automatic launch(input int sel, input int poke_at, output int cyc, output logic done_early);
    load(sel);
    bus.start = 1'b1;
    step();
    bus.start  = 1'b0;
    done_early = bus.done;
    load(3);
    cyc = 0;
    while (cyc < 60) begin
      step();
      cyc++;
      if (bus.done === 1'b1) break;
      bus.start = (cyc == poke_at);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    step();
    step();
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    bad = count_bad(-1);
    n_total++;
    if (bad !== 0) $display("FAIL reset_result_zero: %0d nonzero/X entries, want 0", bad);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_run();
    int cyc;
    logic de;
    launch(0, -1, cyc, de);
    n_total++;
    if (cyc !== 38) $display("FAIL full_latency: done after %0d cycles, want 38", cyc);
    else n_pass++;
    n_total++;
    if (bus.A_result[10][0] !== -16'sd50) $display("FAIL full_r0c0: got %0d want -50", bus.A_result[10][0]);
    else n_pass++;
    n_total++;
    if (bus.A_result[19][9] !== -16'sd50) $display("FAIL full_r0c9: got %0d want -50", bus.A_result[19][9]);
    else n_pass++;
    n_total++;
    if (bus.A_result[11][0] !== -16'sd31) $display("FAIL full_r1c0: got %0d want -31", bus.A_result[11][0]);
    else n_pass++;
    n_total++;
    if (bus.A_result[19][0] !== 16'sd148) $display("FAIL full_r9c0: got %0d want 148", bus.A_result[19][0]);
    else n_pass++;
    n_total++;
    if (bus.A_result[28][9] !== 16'sd148) $display("FAIL full_r9c9: got %0d want 148", bus.A_result[28][9]);
    else n_pass++;
    n_total++;
    if (count_bad(0) !== 0) $display("FAIL full_all: %0d entries differ from model", count_bad(0));
    else n_pass++;
  endtask

  task automatic test_zero_pattern();
    int rows [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 29, 37};
    int nz;
    foreach (rows[i]) begin
      nz = 0;
      for (int j = 0; j < C; j++) if (bus.A_result[rows[i]][j] !== 16'sd0) nz++;
      n_total++;
      if (nz !== 0) $display("FAIL zero_row%0d: %0d nonzero entries, want 0", rows[i], nz);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic de;
    launch(2, -1, cyc, de);
    n_total++;
    if (cyc !== 38) $display("FAIL wrap_latency: done after %0d cycles, want 38", cyc);
    else n_pass++;
    n_total++;
    if (bus.A_result[15][3] !== 16'sd0) $display("FAIL wrap_r2c3: got %0d want 0", bus.A_result[15][3]);
    else n_pass++;
    n_total++;
    if (count_bad(2) !== 0) $display("FAIL wrap_all: %0d entries nonzero, want 0", count_bad(2));
    else n_pass++;
  endtask

  task automatic test_mid_run_reset();
    int cyc;
    logic de;
    load(0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (15) step();
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL midrst_running: done=%b want 0", bus.done);
    else n_pass++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done);
    else n_pass++;
    n_total++;
    if (count_bad(-1) !== 0) $display("FAIL midrst_clear: %0d nonzero entries, want 0", count_bad(-1));
    else n_pass++;
    launch(0, -1, cyc, de);
    n_total++;
    if (cyc !== 38) $display("FAIL midrst_relatency: done after %0d cycles, want 38", cyc);
    else n_pass++;
    n_total++;
    if (count_bad(0) !== 0) $display("FAIL midrst_rerun: %0d entries differ from model", count_bad(0));
    else n_pass++;
  endtask

  task automatic test_restart();
    int cyc;
    logic de;
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL restart_pre_done: got %b want 1", bus.done);
    else n_pass++;
    launch(1, 10, cyc, de);
    n_total++;
    if (de !== 1'b0) $display("FAIL restart_done_falls: got %b want 0", de);
    else n_pass++;
    n_total++;
    if (cyc !== 38) $display("FAIL restart_latency: done after %0d cycles, want 38", cyc);
    else n_pass++;
    n_total++;
    if (bus.A_result[12][1] !== -16'sd25) $display("FAIL restart_r1c1: got %0d want -25", bus.A_result[12][1]);
    else n_pass++;
    n_total++;
    if (bus.A_result[28][9] !== -16'sd225) $display("FAIL restart_r9c9: got %0d want -225", bus.A_result[28][9]);
    else n_pass++;
    n_total++;
    if (count_bad(1) !== 0) $display("FAIL restart_all: %0d entries differ from model", count_bad(1));
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    load(0);
    test_reset();
    test_full_run();
    test_zero_pattern();
    test_wrap();
    test_mid_run_reset();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
